// File: rtl/rc4_ctrl_pkg.sv
// Shared types for the RC4 key-search phase controller: the sequencer state
// encoding, the S-memory phase selector, and default sizing constants.
package rc4_ctrl_pkg;

  localparam int DEF_KEY_WIDTH = 24;
  localparam int DEF_TIMEOUT   = 4096;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_INIT_GO   = 4'd1,
    ST_INIT_WAIT = 4'd2,
    ST_KSA_GO    = 4'd3,
    ST_KSA_WAIT  = 4'd4,
    ST_PRGA_GO   = 4'd5,
    ST_PRGA_WAIT = 4'd6,
    ST_CHECK     = 4'd7,
    ST_NEXT_KEY  = 4'd8,
    ST_DONE_OK   = 4'd9,
    ST_DONE_FAIL = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_INIT = 2'd1,
    PH_KSA  = 2'd2,
    PH_PRGA = 2'd3
  } phase_t;

  // Which phase owns the S-memory port in a given sequencer state.
  function automatic phase_t phase_of(input state_t s);
    phase_t ph;
    ph = PH_NONE;
    case (s)
      ST_INIT_GO, ST_INIT_WAIT: ph = PH_INIT;
      ST_KSA_GO,  ST_KSA_WAIT:  ph = PH_KSA;
      ST_PRGA_GO, ST_PRGA_WAIT: ph = PH_PRGA;
      default:                  ph = PH_NONE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/s_mem_mux.sv
// S-memory write-port mux. Selection depends only on the owning phase, so a
// request from a phase that does not own the port never reaches memory.
module s_mem_mux
  import rc4_ctrl_pkg::*;
(
  input  phase_t     i_phase,
  input  logic [7:0] i_init_addr,
  input  logic [7:0] i_init_data,
  input  logic       i_init_wren,
  input  logic [7:0] i_ksa_addr,
  input  logic [7:0] i_ksa_data,
  input  logic       i_ksa_wren,
  input  logic [7:0] i_prga_addr,
  input  logic [7:0] i_prga_data,
  input  logic       i_prga_wren,
  output logic [7:0] o_s_addr,
  output logic [7:0] o_s_data,
  output logic       o_s_wren
);

  // Route the owning phase's request; drive an inert all-zero request otherwise.
  always_comb begin
    o_s_addr = 8'd0;
    o_s_data = 8'd0;
    o_s_wren = 1'b0;
    case (i_phase)
      PH_INIT: begin
        o_s_addr = i_init_addr;
        o_s_data = i_init_data;
        o_s_wren = i_init_wren;
      end
      PH_KSA: begin
        o_s_addr = i_ksa_addr;
        o_s_data = i_ksa_data;
        o_s_wren = i_ksa_wren;
      end
      PH_PRGA: begin
        o_s_addr = i_prga_addr;
        o_s_data = i_prga_data;
        o_s_wren = i_prga_wren;
      end
      default: begin
        o_s_addr = 8'd0;
        o_s_data = 8'd0;
        o_s_wren = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rc4_phase_ctrl.sv
// RC4 key-search sequencer: for each candidate key runs init, KSA and PRGA in
// order, owns the S-memory write mux, and stops on a valid plaintext or when
// KEY_LAST has been tried. Optional per-phase watchdog under `WATCHDOG_EN`.
module rc4_phase_ctrl
  import rc4_ctrl_pkg::*;
#(
  parameter int                   KEY_WIDTH = DEF_KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST  = KEY_WIDTH'(24'h3FFFFF),
  parameter int                   TIMEOUT   = DEF_TIMEOUT
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 done,
  output logic                 found,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 start_init,
  output logic                 start_ksa,
  output logic                 start_prga,
  input  logic                 finish_init,
  input  logic                 finish_ksa,
  input  logic                 finish_prga,
  input  logic                 prga_valid,
  input  logic [7:0]           init_addr,
  input  logic [7:0]           init_data,
  input  logic                 init_wren,
  input  logic [7:0]           ksa_addr,
  input  logic [7:0]           ksa_data,
  input  logic                 ksa_wren,
  input  logic [7:0]           prga_addr,
  input  logic [7:0]           prga_data,
  input  logic                 prga_wren,
  output logic [7:0]           s_addr,
  output logic [7:0]           s_data,
  output logic                 s_wren,
  output logic                 timeout_err
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [KEY_WIDTH-1:0] r_key;
  logic                 r_valid;
  logic                 r_done;
  logic                 r_found;
  logic                 w_restart;
  logic                 w_waiting;
  logic                 w_wd_trip;
  phase_t               w_phase;

  assign w_restart = start && (r_state == ST_IDLE || r_state == ST_DONE_OK ||
                               r_state == ST_DONE_FAIL);
  assign w_waiting = (r_state == ST_INIT_WAIT) || (r_state == ST_KSA_WAIT) ||
                     (r_state == ST_PRGA_WAIT);

`ifdef WATCHDOG_EN
  localparam int             WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout_err;
  logic            w_finish_cur;
  logic            w_wd_fire;

  assign w_finish_cur = (r_state == ST_INIT_WAIT && finish_init) ||
                        (r_state == ST_KSA_WAIT  && finish_ksa)  ||
                        (r_state == ST_PRGA_WAIT && finish_prga);
  assign w_wd_trip    = w_waiting && (r_wd_cnt == WD_LAST);
  assign w_wd_fire    = w_wd_trip && !w_finish_cur;
  assign timeout_err  = r_timeout_err;

  // Per-phase wait counter: zeroed in each GO state, counts every WAIT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_INIT_GO || r_state == ST_KSA_GO || r_state == ST_PRGA_GO) begin
      r_wd_cnt <= '0;
    end else if (w_waiting) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  // Sticky timeout flag, cleared only when a new search is started.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout_err <= 1'b0;
    end else if (w_wd_fire) begin
      r_timeout_err <= 1'b1;
    end else if (w_restart) begin
      r_timeout_err <= 1'b0;
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_wd_trip        = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and one-cycle phase start pulses decoded from state.
  always_comb begin
    w_state_nxt = r_state;
    start_init  = 1'b0;
    start_ksa   = 1'b0;
    start_prga  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE_OK, ST_DONE_FAIL: begin
        if (start) w_state_nxt = ST_INIT_GO;
      end
      ST_INIT_GO: begin
        start_init  = 1'b1;
        w_state_nxt = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (finish_init)    w_state_nxt = ST_KSA_GO;
        else if (w_wd_trip) w_state_nxt = ST_DONE_FAIL;
      end
      ST_KSA_GO: begin
        start_ksa   = 1'b1;
        w_state_nxt = ST_KSA_WAIT;
      end
      ST_KSA_WAIT: begin
        if (finish_ksa)     w_state_nxt = ST_PRGA_GO;
        else if (w_wd_trip) w_state_nxt = ST_DONE_FAIL;
      end
      ST_PRGA_GO: begin
        start_prga  = 1'b1;
        w_state_nxt = ST_PRGA_WAIT;
      end
      ST_PRGA_WAIT: begin
        if (finish_prga)    w_state_nxt = ST_CHECK;
        else if (w_wd_trip) w_state_nxt = ST_DONE_FAIL;
      end
      ST_CHECK: begin
        if (r_valid)                w_state_nxt = ST_DONE_OK;
        else if (r_key == KEY_LAST) w_state_nxt = ST_DONE_FAIL;
        else                        w_state_nxt = ST_NEXT_KEY;
      end
      ST_NEXT_KEY: w_state_nxt = ST_INIT_GO;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Candidate key: zeroed on a new search, stepped once per NEXT_KEY, never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key <= '0;
    end else if (w_restart) begin
      r_key <= '0;
    end else if (r_state == ST_NEXT_KEY && r_key != {KEY_WIDTH{1'b1}}) begin
      r_key <= r_key + KEY_WIDTH'(1);
    end
  end

  // Capture the PRGA verdict only on the cycle PRGA reports completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    r_valid <= 1'b0;
    else if (r_state == ST_PRGA_WAIT && finish_prga) r_valid <= prga_valid;
  end

  // Registered status: valid from the first cycle of a DONE state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done  <= 1'b0;
      r_found <= 1'b0;
    end else begin
      r_done  <= (w_state_nxt == ST_DONE_OK) || (w_state_nxt == ST_DONE_FAIL);
      r_found <= (w_state_nxt == ST_DONE_OK);
    end
  end

  assign done    = r_done;
  assign found   = r_found;
  assign key     = r_key;
  assign w_phase = phase_of(r_state);

  s_mem_mux u_s_mem_mux (
    .i_phase     (w_phase),
    .i_init_addr (init_addr),
    .i_init_data (init_data),
    .i_init_wren (init_wren),
    .i_ksa_addr  (ksa_addr),
    .i_ksa_data  (ksa_data),
    .i_ksa_wren  (ksa_wren),
    .i_prga_addr (prga_addr),
    .i_prga_data (prga_data),
    .i_prga_wren (prga_wren),
    .o_s_addr    (s_addr),
    .o_s_data    (s_data),
    .o_s_wren    (s_wren)
  );

endmodule
